// File: rtl/queue_serializer_if.sv
// Queue-side pop interface plus serial line and frame status of the byte serializer.
// master = serializer side, slave = queue/consumer side.
interface queue_serializer_if;
  logic       en;
  logic       q_empty;
  logic [7:0] q_data;
  logic       q_dequeue;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;

  modport master (
    input  en, q_empty, q_data,
    output q_dequeue, tx, busy, frame_done, frame_count
  );

  modport slave (
    output en, q_empty, q_data,
    input  q_dequeue, tx, busy, frame_done, frame_count
  );
endinterface

// File: rtl/queue_serializer.sv
// Pops bytes from the queue and sends start/8 data LSB-first/optional even parity/stop on tx;
// 3 edges from sampling a non-empty queue to tx falling; waits in IDLE while en=0 or queue empty.
module queue_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  queue_serializer_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST_CYC = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] cyc_q, cyc_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       deq_q, deq_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] cnt_q, cnt_d;

  logic last_cyc;
  logic start_ok;

  assign last_cyc = (cyc_q == LAST_CYC);
  assign start_ok = bus.en && !bus.q_empty;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    deq_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start_ok) begin
          state_d = REQ;
          deq_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      REQ: state_d = WAIT;
      // The queue presented the popped byte at the REQ->WAIT edge.
      WAIT: begin
        state_d = START;
        shift_d = bus.q_data;
        par_d   = ^bus.q_data;
        tx_d    = 1'b0;
        cyc_d   = 8'd0;
      end
      START: begin
        if (last_cyc) begin
          state_d = DATA;
          cyc_d   = 8'd0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      DATA: begin
        if (last_cyc) begin
          cyc_d = 8'd0;
          if (bit_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      PARITY: begin
        if (last_cyc) begin
          state_d = STOP;
          cyc_d   = 8'd0;
          tx_d    = 1'b1;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      STOP: begin
        if (last_cyc) begin
          cyc_d  = 8'd0;
          done_d = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          if (start_ok) begin
            state_d = REQ;
            deq_d   = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cyc_q   <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      deq_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      deq_q   <= deq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.q_dequeue   = deq_q;
  assign bus.tx          = tx_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_count = cnt_q;
endmodule
